// File: rtl/slice_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b - bin), one SLICE-bit chunk per clock.
// Define SUB_SATURATE_EN to clamp diff to the signed limits on overflow.
module slice_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             bout_q, ovf_q, zero_q;

  int unsigned      base;
  logic [SLICE-1:0] a_s, b_s;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] diff_d, res_d;
  logic             ovf_d;

  // Subtraction as a + ~b + carry, with the carry seeded from ~bin at accept.
  always_comb begin
    base   = 32'(cnt_q) * 32'(SLICE);
    a_s    = SLICE'(a_q >> base);
    b_s    = SLICE'(b_q >> base);
    sum    = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, carry_q};
    diff_d = (diff_q & ~(WIDTH'({SLICE{1'b1}}) << base))
           | (WIDTH'(sum[SLICE-1:0]) << base);
    ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
    res_d  = diff_d;
`ifdef SUB_SATURATE_EN
    if (ovf_d) res_d = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ~bin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= sum[SLICE];
          if (cnt_q == CW'(N - 1)) begin
            diff_q  <= res_d;
            bout_q  <= ~sum[SLICE];
            ovf_q   <= ovf_d;
            zero_q  <= (res_d == '0);
            state_q <= DONE;
          end else begin
            diff_q <= diff_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_slice_serial_subtractor.sv
// Scoreboard bench for slice_serial_subtractor: driver pushes model results, negedge monitor pops.
module tb_slice_serial_subtractor;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bin, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         bout, ovf, zero;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  slice_serial_subtractor #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mbin);
    exp_t         e;
    logic [W:0]   full;
    full   = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    e.d    = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (ma[W-1] != mb[W-1]) && (e.d[W-1] != ma[W-1]);
`ifdef SUB_SATURATE_EN
    if (e.ovf) e.d = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    e.zero = (e.d == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("bout", 32'(bout), 32'(e.bout));
        chk("ovf",  32'(ovf),  32'(e.ovf));
        chk("zero", 32'(zero), 32'(e.zero));
      end
    end
  end

  // Full operation: accept, check latency, hold in DONE for `hold` cycles, then drain.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input int hold);
    exp_t e;
    int   w;
    int   lat;
    e = model(ta, tb_, tbin);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'(1));
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      tick(); lat++;
    end
    chk("latency", 32'(lat), 32'(N));
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", 32'(in_ready), 32'(0));
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      tick();
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_diff", 32'(diff), 32'(e.d));
      chk("hold_flags", 32'({bout, ovf, zero}), 32'({e.bout, e.ovf, e.zero}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ready_after_drain", 32'(in_ready), 32'(1));
    chk("valid_after_drain", 32'(out_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_diff", 32'({diff, bout, ovf, zero}), 32'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));

    run_op(16'h9999, 16'h9FFF, 1'b0, 0);
    run_op(16'h99FD, 16'hBD99, 1'b0, 0);
    run_op(16'h9999, 16'h999F, 1'b0, 1);
    run_op(16'h7FFF, 16'h8000, 1'b0, 0);
    run_op(16'h8000, 16'h7FFF, 1'b0, 0);
    run_op(16'h1234, 16'h1233, 1'b1, 3);
    run_op(16'hABCD, 16'hABCD, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b0, 0);

    // Reset during RUN at k=2: the operation is discarded.
    a = 16'h4444; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_diff", 32'(diff), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    run_op(16'h0005, 16'h0003, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
